// File: rtl/turn_controller_if.sv
// Move-request and board-drop handshake bundle between the two players, the board and turn_controller.
interface turn_controller_if #(
    parameter int COL_W = 3
);
    logic             p1_valid;
    logic [COL_W-1:0] p1_col;
    logic             p1_ready;
    logic             p2_valid;
    logic [COL_W-1:0] p2_col;
    logic             p2_ready;
    logic             drop_req;
    logic [COL_W-1:0] drop_col;
    logic [1:0]       drop_player;
    logic             drop_ack;

    modport master (
        output p1_valid, p1_col, p2_valid, p2_col, drop_ack,
        input  p1_ready, p2_ready, drop_req, drop_col, drop_player
    );

    modport slave (
        input  p1_valid, p1_col, p2_valid, p2_col, drop_ack,
        output p1_ready, p2_ready, drop_req, drop_col, drop_player
    );
endinterface

// File: rtl/turn_controller.sv
// Connect-Four turn sequencer: alternates players, runs the per-turn countdown,
// auto-plays on timeout, drives board drop/clear commands and declares the result.
module turn_controller #(
    parameter int COLS          = 7,
    parameter int TICKS_PER_SEC = 50_000_000,
    parameter int TURN_SECONDS  = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [COLS-1:0]    i_col_full,
    input  logic               i_theres_a_winner,
    input  logic               i_board_full,
    input  logic [1:0]         i_winner,
    turn_controller_if.slave   if_bus,
    output logic               o_board_clear,
    output logic [1:0]         o_current_player,
    output logic [3:0]         o_seconds_left,
    output logic               o_move_rejected,
    output logic               o_timeout_move,
    output logic               o_game_over,
    output logic [1:0]         o_game_winner
);
    localparam int CW = $clog2(COLS);
    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [3:0]    TURN_LOAD  = 4'(TURN_SECONDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_DROP  = 3'd2,
        S_CHECK = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    // Out-of-range columns never match a board column, so they read as not free.
    function automatic logic col_is_free(input logic [CW-1:0] col, input logic [COLS-1:0] full);
        logic ok;
        ok = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (CW'(c) == col) begin
                ok = !full[c];
            end
        end
        return ok;
    endfunction

    // Returns {found, index} of the lowest-numbered column that still has room.
    function automatic logic [CW:0] lowest_free(input logic [COLS-1:0] full);
        logic [CW:0] res;
        res = {1'b0, {CW{1'b0}}};
        for (int c = COLS - 1; c >= 0; c--) begin
            if (!full[c]) begin
                res = {1'b1, CW'(c)};
            end
        end
        return res;
    endfunction

    state_t          r_state;
    state_t          w_state_next;
    logic [1:0]      r_player;
    logic [3:0]      r_seconds;
    logic [PW-1:0]   r_presc;
    logic [CW-1:0]   r_drop_col;
    logic [1:0]      r_drop_player;
    logic [1:0]      r_game_winner;
    logic            r_board_clear;
    logic            r_move_rejected;
    logic            r_timeout_move;

    logic            w_req_valid;
    logic [CW-1:0]   w_req_col;
    logic            w_move_hs;
    logic            w_move_ok;
    logic            w_move_bad;
    logic            w_tick;
    logic            w_expire;
    logic [CW:0]     w_free;
    logic            w_auto;
    logic            w_stuck;

    // Only the current player's request is considered; the other side is ignored.
    always_comb begin
        w_req_valid = (r_player == 2'd1) ? if_bus.p1_valid : if_bus.p2_valid;
        w_req_col   = (r_player == 2'd1) ? if_bus.p1_col   : if_bus.p2_col;
        w_move_hs   = (r_state == S_WAIT) && w_req_valid;
        w_move_ok   = w_move_hs && col_is_free(w_req_col, i_col_full);
        w_move_bad  = w_move_hs && !w_move_ok;
        w_tick      = (r_state == S_WAIT) && (r_presc == PRESC_LAST);
        w_expire    = w_tick && (r_seconds == 4'd1);
        w_free      = lowest_free(i_col_full);
        w_auto      = w_expire && !w_move_ok && w_free[CW];
        w_stuck     = w_expire && !w_move_ok && !w_free[CW];
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; a legal move in the expiry cycle beats the timeout.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_WAIT;
                else         w_state_next = S_IDLE;
            end
            S_WAIT: begin
                if (w_move_ok || w_auto) w_state_next = S_DROP;
                else if (w_stuck)        w_state_next = S_OVER;
                else                     w_state_next = S_WAIT;
            end
            S_DROP: begin
                if (if_bus.drop_ack) w_state_next = S_CHECK;
                else                 w_state_next = S_DROP;
            end
            S_CHECK: begin
                if (i_theres_a_winner || i_board_full) w_state_next = S_OVER;
                else                                   w_state_next = S_WAIT;
            end
            S_OVER: begin
                if (i_start) w_state_next = S_WAIT;
                else         w_state_next = S_OVER;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Turn datapath: player, countdown, latched drop command, result and pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_player        <= 2'd1;
            r_seconds       <= 4'd0;
            r_presc         <= {PW{1'b0}};
            r_drop_col      <= {CW{1'b0}};
            r_drop_player   <= 2'd0;
            r_game_winner   <= 2'd0;
            r_board_clear   <= 1'b0;
            r_move_rejected <= 1'b0;
            r_timeout_move  <= 1'b0;
        end else begin
            r_board_clear   <= 1'b0;
            r_move_rejected <= 1'b0;
            r_timeout_move  <= 1'b0;
            case (r_state)
                S_IDLE, S_OVER: begin
                    if (i_start) begin
                        r_board_clear <= 1'b1;
                        r_player      <= 2'd1;
                        r_seconds     <= TURN_LOAD;
                        r_presc       <= {PW{1'b0}};
                        r_game_winner <= 2'd0;
                    end else begin
                        r_seconds     <= 4'd0;
                    end
                end
                S_WAIT: begin
                    r_move_rejected <= w_move_bad;
                    if (w_tick) begin
                        r_presc   <= {PW{1'b0}};
                        r_seconds <= r_seconds - 4'd1;
                    end else begin
                        r_presc   <= r_presc + PW'(1);
                    end
                    if (w_move_ok) begin
                        r_drop_col    <= w_req_col;
                        r_drop_player <= r_player;
                    end else if (w_auto) begin
                        r_drop_col     <= w_free[CW-1:0];
                        r_drop_player  <= r_player;
                        r_timeout_move <= 1'b1;
                    end else if (w_stuck) begin
                        r_game_winner  <= 2'd0;
                    end
                end
                S_DROP: begin
                    r_presc <= {PW{1'b0}};
                end
                S_CHECK: begin
                    // Four-in-a-row takes priority over a full board.
                    if (i_theres_a_winner) begin
                        r_game_winner <= i_winner;
                        r_seconds     <= 4'd0;
                    end else if (i_board_full) begin
                        r_game_winner <= 2'd0;
                        r_seconds     <= 4'd0;
                    end else begin
                        r_player  <= (r_player == 2'd1) ? 2'd2 : 2'd1;
                        r_seconds <= TURN_LOAD;
                        r_presc   <= {PW{1'b0}};
                    end
                end
                default: begin
                    r_presc <= {PW{1'b0}};
                end
            endcase
        end
    end

    // Output decode from registered state and datapath.
    always_comb begin
        if_bus.p1_ready    = 1'b0;
        if_bus.p2_ready    = 1'b0;
        if_bus.drop_req    = 1'b0;
        if_bus.drop_col    = r_drop_col;
        if_bus.drop_player = r_drop_player;
        o_game_over        = 1'b0;
        case (r_state)
            S_WAIT: begin
                if_bus.p1_ready = (r_player == 2'd1);
                if_bus.p2_ready = (r_player == 2'd2);
            end
            S_DROP:  if_bus.drop_req = 1'b1;
            S_OVER:  o_game_over     = 1'b1;
            default: o_game_over     = 1'b0;
        endcase
        o_board_clear    = r_board_clear;
        o_current_player = r_player;
        o_seconds_left   = r_seconds;
        o_move_rejected  = r_move_rejected;
        o_timeout_move   = r_timeout_move;
        o_game_winner    = r_game_winner;
    end
endmodule

// File: tb/tb_turn_controller.sv
// Directed bench for turn_controller (4 ticks/second, 3-second turns) with a drop scoreboard.
module tb_turn_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset, start, twin, bfull;
    logic [6:0] col_full;
    logic [1:0] winner;
    logic       board_clear, move_rejected, timeout_move, game_over;
    logic [1:0] current_player, game_winner;
    logic [3:0] seconds_left;

    turn_controller_if bus();

    turn_controller #(.COLS(7), .TICKS_PER_SEC(4), .TURN_SECONDS(3)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_col_full(col_full),
        .i_theres_a_winner(twin), .i_board_full(bfull), .i_winner(winner),
        .if_bus(bus), .o_board_clear(board_clear), .o_current_player(current_player),
        .o_seconds_left(seconds_left), .o_move_rejected(move_rejected),
        .o_timeout_move(timeout_move), .o_game_over(game_over), .o_game_winner(game_winner)
    );

    typedef struct packed { logic [2:0] col; logic [1:0] player; } drop_t;
    drop_t sb_q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_drop(input int budget);
        int n = 0;
        while (bus.drop_req !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("drop_req_seen", 32'(bus.drop_req), 32'd1);
    endtask

    task automatic pop_drop();
        drop_t e;
        chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("drop_col", 32'(bus.drop_col), 32'(e.col));
            chk("drop_player", 32'(bus.drop_player), 32'(e.player));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; col_full = 7'd0; twin = 1'b0; bfull = 1'b0; winner = 2'd0;
        bus.p1_valid = 1'b0; bus.p1_col = 3'd0; bus.p2_valid = 1'b0; bus.p2_col = 3'd0;
        bus.drop_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_player", 32'(current_player), 32'd1);
        chk("rst_seconds", 32'(seconds_left), 32'd0);
        chk("rst_winner", 32'(game_winner), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_drop_req", 32'(bus.drop_req), 32'd0);
        chk("rst_p1_ready", 32'(bus.p1_ready), 32'd0);
        chk("rst_board_clear", 32'(board_clear), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // New game.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_clear", 32'(board_clear), 32'd1);
        chk("start_player", 32'(current_player), 32'd1);
        chk("start_p1_ready", 32'(bus.p1_ready), 32'd1);
        chk("start_p2_ready", 32'(bus.p2_ready), 32'd0);
        chk("start_seconds", 32'(seconds_left), 32'd3);

        // P1 plays column 3, ack two cycles late.
        bus.p1_valid = 1'b1; bus.p1_col = 3'd3;
        sb_q.push_back('{col: 3'd3, player: 2'd1});
        @(negedge clk);
        bus.p1_valid = 1'b0;
        chk("clear_pulse_end", 32'(board_clear), 32'd0);
        wait_drop(4);
        pop_drop();
        chk("drop_p1_ready", 32'(bus.p1_ready), 32'd0);
        repeat (2) @(negedge clk);
        chk("drop_hold_req", 32'(bus.drop_req), 32'd1);
        chk("drop_hold_col", 32'(bus.drop_col), 32'd3);
        bus.drop_ack = 1'b1;
        @(negedge clk);
        bus.drop_ack = 1'b0;
        chk("check_drop_low", 32'(bus.drop_req), 32'd0);
        @(negedge clk);
        chk("turn2_player", 32'(current_player), 32'd2);
        chk("turn2_p2_ready", 32'(bus.p2_ready), 32'd1);
        chk("turn2_p1_ready", 32'(bus.p1_ready), 32'd0);
        chk("turn2_seconds", 32'(seconds_left), 32'd3);

        // P2 offers a full column while P1 pushes out of turn.
        col_full = 7'b0100000;
        bus.p2_valid = 1'b1; bus.p2_col = 3'd5;
        bus.p1_valid = 1'b1; bus.p1_col = 3'd0;
        @(negedge clk);
        chk("reject_pulse", 32'(move_rejected), 32'd1);
        chk("reject_no_drop", 32'(bus.drop_req), 32'd0);
        chk("reject_stay", 32'(bus.p2_ready), 32'd1);
        bus.p1_valid = 1'b0; bus.p2_col = 3'd6;
        sb_q.push_back('{col: 3'd6, player: 2'd2});
        @(negedge clk);
        bus.p2_valid = 1'b0;
        chk("reject_pulse_end", 32'(move_rejected), 32'd0);
        wait_drop(4);
        pop_drop();
        bus.drop_ack = 1'b1;
        col_full = 7'b0000011;
        @(negedge clk);
        bus.drop_ack = 1'b0;
        chk("check2_drop_low", 32'(bus.drop_req), 32'd0);
        @(negedge clk);

        // P1 idles: countdown then auto-move into the lowest free column.
        sb_q.push_back('{col: 3'd2, player: 2'd1});
        for (int k = 1; k <= 12; k++) begin
            if (k % 4 == 1) chk("countdown", 32'(seconds_left), 32'(3 - (k - 1) / 4));
            if (k == 12) chk("pre_timeout_idle", 32'(bus.drop_req), 32'd0);
            @(negedge clk);
        end
        chk("timeout_pulse", 32'(timeout_move), 32'd1);
        chk("timeout_seconds", 32'(seconds_left), 32'd0);
        wait_drop(1);
        pop_drop();
        bus.drop_ack = 1'b1;
        @(negedge clk);
        bus.drop_ack = 1'b0;
        twin = 1'b1; winner = 2'd2; bfull = 1'b1;
        chk("timeout_pulse_end", 32'(timeout_move), 32'd0);
        @(negedge clk);
        twin = 1'b0; winner = 2'd0; bfull = 1'b0;
        chk("over_flag", 32'(game_over), 32'd1);
        chk("over_winner", 32'(game_winner), 32'd2);
        chk("over_seconds", 32'(seconds_left), 32'd0);
        chk("over_p1_ready", 32'(bus.p1_ready), 32'd0);
        @(negedge clk);
        chk("over_held", 32'(game_over), 32'd1);

        // Restart from GAME_OVER.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_clear", 32'(board_clear), 32'd1);
        chk("restart_over", 32'(game_over), 32'd0);
        chk("restart_winner", 32'(game_winner), 32'd0);
        chk("restart_player", 32'(current_player), 32'd1);
        col_full = 7'd0;
        bus.p1_valid = 1'b1; bus.p1_col = 3'd7;
        @(negedge clk);
        bus.p1_valid = 1'b0;
        chk("range_reject", 32'(move_rejected), 32'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_ignored", 32'(board_clear), 32'd0);

        // Legal move in the expiry cycle wins over the timeout.
        repeat (9) @(negedge clk);
        chk("tie_seconds", 32'(seconds_left), 32'd1);
        bus.p1_valid = 1'b1; bus.p1_col = 3'd4;
        sb_q.push_back('{col: 3'd4, player: 2'd1});
        @(negedge clk);
        bus.p1_valid = 1'b0;
        chk("tie_no_timeout", 32'(timeout_move), 32'd0);
        wait_drop(1);
        pop_drop();

        // Reset while a drop is pending.
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_drop", 32'(bus.drop_req), 32'd0);
        chk("rst_mid_seconds", 32'(seconds_left), 32'd0);
        chk("rst_mid_player", 32'(current_player), 32'd1);
        reset = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rst_restart_clear", 32'(board_clear), 32'd1);
        chk("rst_restart_ready", 32'(bus.p1_ready), 32'd1);
        chk("rst_restart_seconds", 32'(seconds_left), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
